// File: rtl/preamble_1001_tx_if.sv
// Payload handshake between a word producer and the preamble_1001_tx
// serialiser. The producer is the master; the transmitter is the slave.
interface preamble_1001_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/preamble_1001_tx.sv
// Frame transmitter: accepts a payload word, then sends a 4-bit sync
// preamble, the payload MSB first, and a run of zero gap cycles on a single
// serial line. All outputs are registered. Each output register is loaded
// from the decode of the next state, so it always reflects the state the
// FSM occupies during that cycle.
module preamble_1001_tx #(
    parameter int          DATA_W   = 8,
    parameter logic [3:0]  PREAMBLE = 4'b1001,
    parameter int          GAP_LEN  = 2
) (
    input  logic               clk,
    input  logic               reset,
    preamble_1001_tx_if.slave  s_in,
    output logic               ser_out,
    output logic               busy,
    output logic               frame_done
);

    // The bit counter covers both the 4 preamble bits and the DATA_W payload bits.
    localparam int BIT_MAX = (DATA_W > 4) ? DATA_W : 4;
    localparam int CNT_W   = $clog2(BIT_MAX);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRE,
        S_DATA,
        S_GAP
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [3:0]          r_gcnt;
    logic [3:0]          w_gcnt_nxt;
    logic [DATA_W-1:0]   r_shift;
    logic [DATA_W-1:0]   w_shift_nxt;

    logic                r_ser;
    logic                r_busy;
    logic                r_done;
    logic                r_ready;
    logic                w_ser_nxt;
    logic                w_busy_nxt;
    logic                w_done_nxt;
    logic                w_ready_nxt;

    logic                w_accept;
    logic [1:0]          w_pre_idx;

    // in_ready is a pure function of the IDLE state, so there is no path
    // from in_valid back to in_ready.
    assign w_accept = (r_state == S_IDLE) && s_in.in_valid;

    // Next-state logic: counters clear on every state entry.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_gcnt_nxt  = r_gcnt;
        w_shift_nxt = r_shift;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_PRE;
                    w_cnt_nxt   = '0;
                    w_gcnt_nxt  = '0;
                    w_shift_nxt = s_in.in_data;
                end
            end
            S_PRE: begin
                if (r_cnt == CNT_W'(3)) begin
                    w_state_nxt = S_DATA;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (r_cnt == CNT_W'(DATA_W - 1)) begin
                    w_state_nxt = S_GAP;
                    w_cnt_nxt   = '0;
                    w_gcnt_nxt  = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                    w_shift_nxt = r_shift << 1;
                end
            end
            S_GAP: begin
                if (r_gcnt == 4'(GAP_LEN - 1)) begin
                    w_state_nxt = S_IDLE;
                    w_gcnt_nxt  = '0;
                end else begin
                    w_gcnt_nxt = r_gcnt + 4'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_gcnt_nxt  = '0;
            end
        endcase
    end

    // Moore output decode of the state being entered.
    always_comb begin
        w_ser_nxt   = 1'b0;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_ready_nxt = 1'b0;
        w_pre_idx   = 2'd3 - w_cnt_nxt[1:0];
        case (w_state_nxt)
            S_IDLE: begin
                w_ready_nxt = 1'b1;
            end
            S_PRE: begin
                w_busy_nxt = 1'b1;
                w_ser_nxt  = PREAMBLE[w_pre_idx];
            end
            S_DATA: begin
                w_busy_nxt = 1'b1;
                w_ser_nxt  = w_shift_nxt[DATA_W-1];
            end
            S_GAP: begin
                w_busy_nxt = 1'b1;
                w_done_nxt = (w_gcnt_nxt == 4'd0);
            end
            default: begin
                w_ready_nxt = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs; reset abandons any partial frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_gcnt  <= '0;
            r_ser   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gcnt  <= w_gcnt_nxt;
            r_ser   <= w_ser_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_ready <= w_ready_nxt;
        end
    end

    // Payload shift register; its content only matters while in DATA.
    always_ff @(posedge clk) begin
        r_shift <= w_shift_nxt;
    end

    assign s_in.in_ready = r_ready;
    assign ser_out       = r_ser;
    assign busy          = r_busy;
    assign frame_done    = r_done;

endmodule
